ice40_himax_cam_emu: RTL and testbench
======================================

ICE40_HIMAX_CAM_EMU -- requirements
Module: ice40_himax_cam_emu

Interface
REQ-001 SHALL have parameter H_ACT, default 324, active pixels per line (1..1023).
REQ-002 SHALL have parameter H_BLK, default 16, horizontal blanking cycles per line (1..1023).
REQ-003 SHALL have parameter V_ACT, default 324, active lines per frame (1..1023).
REQ-004 SHALL have parameters VS_W, default 8 (vsync cycles); V_BP, default 64 (cycles vsync-to-first-line); V_FP, default 4096 (cycles last-line-to-next-vsync); each 1..65535.
REQ-005 SHALL have port i_pclk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port i_en  input  1  start/continue frame generation.
REQ-008 SHALL have port o_cam_vsync  output  1  frame sync, active high.
REQ-009 SHALL have port o_cam_hsync  output  1  line valid, high during active pixels.
REQ-010 SHALL have port o_cam_data  output  8  pixel data.
REQ-011 SHALL have port o_frame_done  output  1  one-cycle pulse at end of front porch.
REQ-012 SHALL have port o_frame_cnt  output  8  completed-frame count, wraps 255->0.

Function
REQ-013 SHALL implement states S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLK, S_VFP; all outputs registered.
REQ-014 S_IDLE: all outputs 0 except o_frame_cnt held; i_en=1 sampled -> S_VSYNC next cycle.
REQ-015 S_VSYNC: o_cam_vsync=1 exactly VS_W cycles, then S_VBP.
REQ-016 S_VBP: V_BP cycles, outputs low, row=0, then S_LINE.
REQ-017 S_LINE: o_cam_hsync=1 exactly H_ACT cycles, col 0..H_ACT-1, then S_HBLK.
REQ-018 S_HBLK: H_BLK cycles low; then row<V_ACT-1 -> row+1, S_LINE; else S_VFP.
REQ-019 S_VFP: V_FP cycles; last cycle pulses o_frame_done, increments o_frame_cnt; then i_en=1 -> S_VSYNC, else S_IDLE.
REQ-020 Frame period SHALL be VS_W+V_BP+V_ACT*(H_ACT+H_BLK)+V_FP cycles, back-to-back, no idle gap while i_en=1.
REQ-021 i_en deassert mid-frame SHALL NOT truncate: current frame completes, then S_IDLE.
REQ-022 o_cam_data SHALL equal (col+row) mod 256 while o_cam_hsync=1, else 0.
REQ-023 o_cam_vsync and o_cam_hsync SHALL never be high in the same cycle.
REQ-024 Counters: col/row 10 bits, blanking/sync 16 bits; o_frame_cnt wraps silently.

Reset
REQ-025 resetn=0 SHALL asynchronously force S_IDLE, all counters 0, all outputs 0, including mid-line or mid-vsync.
REQ-026 After resetn release, first o_cam_vsync SHALL rise 2 cycles after first cycle with i_en=1 sampled.

Configuration
REQ-027 Macro CAM_EMU_FRMCNT_EN defined: o_cam_data during active = (col+row+o_frame_cnt) mod 256, giving per-frame distinct pattern.
REQ-028 Macro CAM_EMU_FRMCNT_EN undefined: o_cam_data per REQ-022; all other behaviour identical.

Verification (params H_ACT=4, H_BLK=2, V_ACT=3, VS_W=2, V_BP=1, V_FP=3; period 24)
REQ-029 Reset release, i_en=1 held -> vsync high 2 cycles, hsync rises 1 cycle after vsync falls, o_frame_done pulses every 24 cycles.
REQ-030 Line 1 active -> o_cam_data 1,2,3,4; hsync low 2 cycles between lines; 3 hsync pulses per frame.
REQ-031 i_en dropped during row 1 -> frame completes, o_frame_done=1, o_frame_cnt 0->1, then S_IDLE, no further vsync.
REQ-032 resetn=0 mid-line -> hsync, data, o_frame_cnt to 0 same cycle without clock edge.
REQ-033 256 frames run -> o_frame_cnt wraps 255->0; with CAM_EMU_FRMCNT_EN, frame 2 row 0 data = 2,3,4,5.

Source files
------------

// File: rtl/ice40_himax_cam_emu_if.sv
// Camera-side output bundle of the HiMax sensor emulator.
// The emulator drives the master modport; a sink or bench observes through slave.
interface ice40_himax_cam_emu_if;
    logic       o_cam_vsync;
    logic       o_cam_hsync;
    logic [7:0] o_cam_data;
    logic       o_frame_done;
    logic [7:0] o_frame_cnt;

    modport master (
        output o_cam_vsync,
        output o_cam_hsync,
        output o_cam_data,
        output o_frame_done,
        output o_frame_cnt
    );

    modport slave (
        input o_cam_vsync,
        input o_cam_hsync,
        input o_cam_data,
        input o_frame_done,
        input o_frame_cnt
    );
endinterface

// File: rtl/ice40_himax_cam_emu.sv
// HiMax-style camera emulator: vsync / back porch / lines / front porch frame generator.
// Define CAM_EMU_FRMCNT_EN to mix the frame count into the pixel pattern.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | outputs low, frame count held, waiting for registered i_en
// S_VSYNC  | vsync high for VS_W cycles
// S_VBP    | V_BP quiet cycles before the first line, row reset to 0
// S_LINE   | hsync high for H_ACT cycles, pixel data = col+row(+frame)
// S_HBLK   | H_BLK quiet cycles, then next line or front porch
// S_VFP    | V_FP quiet cycles, frame_done + count bump on the last one
module ice40_himax_cam_emu #(
    parameter int H_ACT = 324,
    parameter int H_BLK = 16,
    parameter int V_ACT = 324,
    parameter int VS_W  = 8,
    parameter int V_BP  = 64,
    parameter int V_FP  = 4096
) (
    input  logic                         i_pclk_in,
    input  logic                         resetn,
    input  logic                         i_en,
    ice40_himax_cam_emu_if.master        cam
);

    localparam logic [9:0]  COL_LAST = 10'(H_ACT - 1);
    localparam logic [9:0]  ROW_LAST = 10'(V_ACT - 1);
    localparam logic [15:0] VS_LOAD  = 16'(VS_W - 1);
    localparam logic [15:0] VBP_LOAD = 16'(V_BP - 1);
    localparam logic [15:0] HBL_LOAD = 16'(H_BLK - 1);
    localparam logic [15:0] VFP_LOAD = 16'(V_FP - 1);

`ifdef CAM_EMU_FRMCNT_EN
    localparam bit FRMCNT_ADD = 1'b1;
`else
    localparam bit FRMCNT_ADD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_LINE,
        S_HBLK,
        S_VFP
    } state_t;

    state_t      state;
    logic        en_q;
    logic [15:0] cnt;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        vsync_q;
    logic        hsync_q;
    logic [7:0]  data_q;
    logic        frame_done_q;
    logic [7:0]  frame_cnt_q;

    function automatic logic [7:0] pix(input logic [9:0] c, input logic [9:0] r,
                                       input logic [7:0] fc);
        logic [9:0] sum;
        sum = c + r + (FRMCNT_ADD ? {2'b00, fc} : 10'd0);
        return sum[7:0];
    endfunction

    // Outputs are loaded together with the state they belong to, so they line up with it.
    always_ff @(posedge i_pclk_in or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            en_q         <= 1'b0;
            cnt          <= 16'd0;
            col          <= 10'd0;
            row          <= 10'd0;
            vsync_q      <= 1'b0;
            hsync_q      <= 1'b0;
            data_q       <= 8'd0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            en_q         <= i_en;
            frame_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    vsync_q <= 1'b0;
                    hsync_q <= 1'b0;
                    data_q  <= 8'd0;
                    col     <= 10'd0;
                    row     <= 10'd0;
                    if (en_q) begin
                        state   <= S_VSYNC;
                        vsync_q <= 1'b1;
                        cnt     <= VS_LOAD;
                    end
                end
                S_VSYNC: begin
                    if (cnt == 16'd0) begin
                        state   <= S_VBP;
                        vsync_q <= 1'b0;
                        cnt     <= VBP_LOAD;
                        row     <= 10'd0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_VBP: begin
                    if (cnt == 16'd0) begin
                        state   <= S_LINE;
                        hsync_q <= 1'b1;
                        col     <= 10'd0;
                        data_q  <= pix(10'd0, row, frame_cnt_q);
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_LINE: begin
                    if (col == COL_LAST) begin
                        state   <= S_HBLK;
                        hsync_q <= 1'b0;
                        data_q  <= 8'd0;
                        cnt     <= HBL_LOAD;
                    end else begin
                        col    <= col + 10'd1;
                        data_q <= pix(col + 10'd1, row, frame_cnt_q);
                    end
                end
                S_HBLK: begin
                    if (cnt == 16'd0) begin
                        if (row == ROW_LAST) begin
                            state <= S_VFP;
                            cnt   <= VFP_LOAD;
                            if (VFP_LOAD == 16'd0) begin
                                frame_done_q <= 1'b1;
                                frame_cnt_q  <= frame_cnt_q + 8'd1;
                            end
                        end else begin
                            state   <= S_LINE;
                            row     <= row + 10'd1;
                            col     <= 10'd0;
                            hsync_q <= 1'b1;
                            data_q  <= pix(10'd0, row + 10'd1, frame_cnt_q);
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_VFP: begin
                    if (cnt == 16'd0) begin
                        if (en_q) begin
                            state   <= S_VSYNC;
                            vsync_q <= 1'b1;
                            cnt     <= VS_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                        // Pulse lands on the final front-porch cycle.
                        if (cnt == 16'd1) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    vsync_q <= 1'b0;
                    hsync_q <= 1'b0;
                    data_q  <= 8'd0;
                end
            endcase
        end
    end

    assign cam.o_cam_vsync  = vsync_q;
    assign cam.o_cam_hsync  = hsync_q;
    assign cam.o_cam_data   = data_q;
    assign cam.o_frame_done = frame_done_q;
    assign cam.o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ice40_himax_cam_emu.sv
// Bench for ice40_himax_cam_emu: frame-phase model checked every cycle plus directed literals.
module tb_ice40_himax_cam_emu;
    localparam int H_ACT = 4;
    localparam int H_BLK = 2;
    localparam int V_ACT = 3;
    localparam int VS_W  = 2;
    localparam int V_BP  = 1;
    localparam int V_FP  = 3;
    localparam int LINE  = H_ACT + H_BLK;
    localparam int PER   = VS_W + V_BP + V_ACT * LINE + V_FP;
`ifdef CAM_EMU_FRMCNT_EN
    localparam int FC_W = 1;
`else
    localparam int FC_W = 0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic i_en   = 1'b0;
    bit   mon_en = 1'b0;

    ice40_himax_cam_emu_if cam_if ();

    ice40_himax_cam_emu #(
        .H_ACT(H_ACT), .H_BLK(H_BLK), .V_ACT(V_ACT),
        .VS_W(VS_W), .V_BP(V_BP), .V_FP(V_FP)
    ) dut (
        .i_pclk_in(clk),
        .resetn   (resetn),
        .i_en     (i_en),
        .cam      (cam_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame timeline, plus completed-frame count.
    bit m_act = 1'b0;
    int m_p   = 0;
    int m_cnt = 0;
    bit m_en  = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act <= 1'b0;
            m_p   <= 0;
            m_cnt <= 0;
            m_en  <= 1'b0;
        end else begin
            m_en <= i_en;
            if (m_act) begin
                if (m_p == PER - 1) begin
                    if (m_en) m_p <= 0;
                    else      m_act <= 1'b0;
                end else begin
                    m_p <= m_p + 1;
                    if (m_p + 1 == PER - 1) m_cnt <= (m_cnt + 1) % 256;
                end
            end else if (m_en) begin
                m_act <= 1'b1;
                m_p   <= 0;
            end
        end
    end

    function automatic void model_out(output bit vs, output bit hs, output int d, output bit fd);
        int q;
        vs = 1'b0; hs = 1'b0; d = 0; fd = 1'b0;
        if (m_act) begin
            if (m_p < VS_W) vs = 1'b1;
            q = m_p - VS_W - V_BP;
            if (q >= 0 && q < V_ACT * LINE && (q % LINE) < H_ACT) begin
                hs = 1'b1;
                d  = ((q % LINE) + (q / LINE) + FC_W * m_cnt) % 256;
            end
            fd = (m_p == PER - 1);
        end
    endfunction

    always @(negedge clk) begin
        bit evs, ehs, efd;
        int ed;
        if (mon_en && resetn) begin
            model_out(evs, ehs, ed, efd);
            chk("vsync",      32'(cam_if.o_cam_vsync),  32'(evs));
            chk("hsync",      32'(cam_if.o_cam_hsync),  32'(ehs));
            chk("data",       32'(cam_if.o_cam_data),   32'(ed));
            chk("frame_done", 32'(cam_if.o_frame_done), 32'(efd));
            chk("frame_cnt",  32'(cam_if.o_frame_cnt),  32'(m_cnt));
            chk("vs_hs_excl", 32'(cam_if.o_cam_vsync & cam_if.o_cam_hsync), 32'd0);
        end
    end

    logic       cvs [64];
    logic       chs [64];
    logic       cfd [64];
    logic [7:0] cdt [64];
    logic [7:0] cfc [64];

    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cvs[i] = cam_if.o_cam_vsync;
            chs[i] = cam_if.o_cam_hsync;
            cfd[i] = cam_if.o_frame_done;
            cdt[i] = cam_if.o_cam_data;
            cfc[i] = cam_if.o_frame_cnt;
            if (i == drop_at) i_en = 1'b0;
        end
    endtask

    initial begin
        int         r;
        int         ndone;
        int         k;
        logic [7:0] d2 [4];

        repeat (3) @(negedge clk);
        chk("rst_vsync", 32'(cam_if.o_cam_vsync),  32'd0);
        chk("rst_hsync", 32'(cam_if.o_cam_hsync),  32'd0);
        chk("rst_data",  32'(cam_if.o_cam_data),   32'd0);
        chk("rst_done",  32'(cam_if.o_frame_done), 32'd0);
        chk("rst_cnt",   32'(cam_if.o_frame_cnt),  32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Start-up latency, frame shape and back-to-back period.
        i_en = 1'b1;
        capture(50, -1);
        chk("vs_lat0", 32'(cvs[0]), 32'd0);
        chk("vs_lat1", 32'(cvs[1]), 32'd1);
        chk("vs_w2",   32'(cvs[2]), 32'd1);
        chk("vs_fall", 32'(cvs[3]), 32'd0);
        chk("hs_bp",   32'(chs[3]), 32'd0);
        chk("hs_rise", 32'(chs[4]), 32'd1);
        for (int i = 0; i < 4; i++) chk("row1_data", 32'(cdt[10 + i]), 32'(i + 1));
        chk("hblk0", 32'(chs[14]), 32'd0);
        chk("hblk1", 32'(chs[15]), 32'd0);
        chk("row2_rise", 32'(chs[16]), 32'd1);
        r = 0;
        for (int i = 1; i <= 24; i++) if (chs[i] && !chs[i - 1]) r++;
        chk("hs_pulses", 32'(r), 32'd3);
        chk("done_pre",  32'(cfd[23]), 32'd0);
        chk("done_1",    32'(cfd[24]), 32'd1);
        chk("cnt_pre",   32'(cfc[23]), 32'd0);
        chk("cnt_1",     32'(cfc[24]), 32'd1);
        chk("vs_next",   32'(cvs[25]), 32'd1);
        chk("done_2",    32'(cfd[48]), 32'd1);

        // Drop i_en during row 1: frame completes then idles.
        @(negedge clk);
        resetn = 1'b0;
        i_en   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        i_en = 1'b1;
        capture(41, 11);
        chk("drop_row1", 32'(chs[11]), 32'd1);
        chk("drop_done", 32'(cfd[24]), 32'd1);
        chk("drop_cnt",  32'(cfc[24]), 32'd1);
        r = 0;
        for (int i = 25; i <= 40; i++) if (cvs[i]) r++;
        chk("drop_no_vs", 32'(r), 32'd0);
        chk("drop_cnt_hold", 32'(cfc[40]), 32'd1);

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        i_en = 1'b1;
        capture(30, -1);
        chk("mid_hs",  32'(chs[29]), 32'd1);
        chk("mid_cnt", 32'(cfc[29]), 32'd2);
        chk("mid_dat", 32'(cdt[29]), 32'(1 + 2 * FC_W));
        #2 resetn = 1'b0;
        #1;
        chk("arst_hsync", 32'(cam_if.o_cam_hsync),  32'd0);
        chk("arst_data",  32'(cam_if.o_cam_data),   32'd0);
        chk("arst_cnt",   32'(cam_if.o_frame_cnt),  32'd0);
        chk("arst_vsync", 32'(cam_if.o_cam_vsync),  32'd0);
        chk("arst_done",  32'(cam_if.o_frame_done), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // 256 frames: counter wrap, and frame 2 row 0 pattern.
        ndone = 0;
        k     = -100;
        for (int i = 0; i < 4; i++) d2[i] = 8'hxx;
        for (int cyc = 0; cyc < PER * 256 + 100; cyc++) begin
            @(negedge clk);
            if (k >= 0 && cyc >= k + 4 && cyc <= k + 7) d2[cyc - k - 4] = cam_if.o_cam_data;
            if (cam_if.o_frame_done) begin
                ndone++;
                if (ndone == 2) k = cyc;
                if (ndone == 255) chk("cnt_255", 32'(cam_if.o_frame_cnt), 32'd255);
                if (ndone == 256) begin
                    chk("cnt_wrap", 32'(cam_if.o_frame_cnt), 32'd0);
                    break;
                end
            end
        end
        chk("frames_run", 32'(ndone), 32'd256);
        for (int i = 0; i < 4; i++) chk("f2_row0", 32'(d2[i]), 32'(i + 2 * FC_W));

        i_en = 1'b0;
        repeat (30) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
